mxint8_bd_seq: RTL and testbench
================================

# mxint8_bd_seq

Block sequencer for the MXINT8 block-decomposition path. Accepts a stream of FP32 elements, buffers one block, and computes the block's shared E8M0 scale on the fly. It then replays the buffered elements, each tagged with the final scale and position, to the downstream per-element FP32→INT8 quantizer. It sits between the FP32 source and the `mx_int8_bd` element converter. Rounding, carry and scale-overflow handling stay in the converter.

## Interface
- `BLOCK_SIZE`, 32: elements per MX block; legal range ≥2.
- `IDX_W`, `$clog2(BLOCK_SIZE)`: element index width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_fp32_i`  in  32  FP32 element (sign, 8-bit exponent, 23-bit mantissa).
- `in_valid_i`  in  1  input element valid.
- `in_last_i`  in  1  element closes a short block; ignored unless `in_valid_i`.
- `in_ready_o`  out  1  sequencer accepts an element this cycle.
- `out_fp32_o`  out  32  buffered element replayed to the converter.
- `out_scale_o`  out  8  shared E8M0 scale of the current block.
- `out_idx_o`  out  IDX_W  element position within the block, 0-based.
- `out_first_o`  out  1  beat is element 0.
- `out_last_o`  out  1  beat is the final element of the block.
- `out_valid_o`  out  1  output beat valid.
- `out_ready_i`  in  1  converter accepts the beat.
- `nan_blk_o`  out  1  current block scale is NaN (`8'hFF`); valid with `out_valid_o`.
- `busy_o`  out  1  high in DRAIN.

## Operation
- Two states: FILL and DRAIN.
- Storage: `BLOCK_SIZE`×32 register buffer, fill counter `wcnt`, read counter `rcnt`, stored length `len`, running scale `scale_q`.
- **FILL**
  - `in_ready_o`=1.
  - Each handshake (`in_valid_i && in_ready_o`) writes `buf[wcnt]` and increments `wcnt`.
  - Each handshake updates `scale_q` from the element's effective exponent `e`:
    - exponent field 255 (Inf or NaN): `e`=255.
    - exponent field 0 (zero or subnormal): `e`=1.
    - otherwise: `e`=exponent field.
  - Update rule: `scale_q` = max(`scale_q`, `e`), except `scale_q` sticks at 255 once reached.
  - `scale_q` starts each block at 0; the first element loads it directly.
  - The block closes on a handshake with `wcnt`==`BLOCK_SIZE`-1, or with `in_last_i`=1.
  - On close: `len` = `wcnt`+1, next state is DRAIN, `rcnt`=0.
- **DRAIN**
  - `in_ready_o`=0.
  - `out_valid_o`=1.
  - `out_fp32_o`=`buf[rcnt]`, `out_scale_o`=`scale_q`, `out_idx_o`=`rcnt`.
  - `out_first_o` = (`rcnt`==0).
  - `out_last_o` = (`rcnt`==`len`-1).
  - `nan_blk_o` = (`scale_q`==255).
  - On output handshake: `rcnt` increments. If `out_last_o`, next state is FILL, `wcnt`=0 and `scale_q` is cleared.
- Short block: only `len` beats are emitted; no padding elements are produced.
- The scale for INT8 elements (emax 0) equals the block's maximum biased exponent. Mantissa-carry scale bumps are the converter's responsibility.

## Timing
- Reset values:
  - State FILL.
  - `wcnt`, `rcnt`, `len`, `scale_q` = 0.
  - `in_ready_o`=1.
  - `out_valid_o`, `out_first_o`, `out_last_o`, `nan_blk_o`, `busy_o` = 0.
  - `out_fp32_o`, `out_scale_o`, `out_idx_o` = 0.
  - Buffer contents undefined.
- Reset asserted mid-FILL or mid-DRAIN discards the partial block immediately; no beat is emitted after reset releases.
- Latency: the first output beat is valid the cycle after the closing input handshake.
- Throughput: an N-element block takes N accept cycles plus N drain cycles at full rate. Input and output never overlap.
- `in_ready_o` rises the cycle after the final output handshake.
- All outputs are registered or decoded from registered state only. There is no combinational path from `out_ready_i` or `in_valid_i` to any output.
- Backpressure: while `out_valid_o && !out_ready_i`, every output holds stable.
- `in_last_i` on the `BLOCK_SIZE`-th element is redundant; the block closes once.
- `len`==1 block: the single beat has `out_first_o`=`out_last_o`=1.

## Test plan
- **Normal block** (`BLOCK_SIZE`=4): input 0x3F800000, 0x40400000, 0xC1200000, 0x00000000 → four beats in order, idx 0..3. Every beat has `out_scale_o`=0x82 and `nan_blk_o`=0. First beat has `out_first_o`=1; idx 3 has `out_last_o`=1.
- **NaN/Inf block**: input 0x3F800000, 0x7FC00000, 0x42000000, 0x7F800000 → `out_scale_o`=0xFF and `nan_blk_o`=1 on all beats.
- **Zero and subnormal block**: input 0x00000000, 0x80000000, 0x00000001, 0x807FFFFF → `out_scale_o`=0x01. The mantissas are replayed bit-exact.
- **Short block**: two elements, 0x40000000 then 0x3F000000 with `in_last_i`=1 → exactly 2 beats, scale 0x80, `out_last_o` on idx 1. The next block's scale is computed from its own elements only.
- **Backpressure**: hold `out_ready_i`=0 for 3 cycles at idx 2 → outputs are unchanged for those cycles and `in_ready_o` stays 0. After release, the remaining beats complete and `in_ready_o`=1 one cycle after the last handshake.
- **Reset mid-DRAIN**: assert `rst_n`=0 after beat idx 1 → all outputs are reset values that cycle. A fresh block then produces its correct scale with no stale beats.

Source files
------------

// File: rtl/mxint8_bd_seq.sv
// MXINT8 block sequencer: buffers one block of FP32 elements while tracking the
// shared E8M0 scale, then replays the block tagged with scale and position.
module mxint8_bd_seq #(
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned IDX_W      = $clog2(BLOCK_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       in_fp32_i,
  input  logic              in_valid_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic [31:0]       out_fp32_o,
  output logic [7:0]        out_scale_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              out_first_o,
  output logic              out_last_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              nan_blk_o,
  output logic              busy_o
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SCALE_W = 8;
  localparam int unsigned LEN_W   = IDX_W + 1;
  localparam logic [IDX_W-1:0]   LAST_WIDX = IDX_W'(BLOCK_SIZE - 1);
  localparam logic [SCALE_W-1:0] SCALE_NAN = 8'hFF;

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t state_q, state_n;

  logic [DATA_W-1:0]  mem_q [BLOCK_SIZE];
  logic [IDX_W-1:0]   wcnt_q, wcnt_n;
  logic [IDX_W-1:0]   rcnt_q, rcnt_n;
  logic [IDX_W-1:0]   rcnt_inc;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [SCALE_W-1:0] scale_q, scale_n;

  logic [SCALE_W-1:0] exp_fld, e_in, scale_upd;
  logic               in_hs, out_hs;

  logic               ready_n, valid_n, first_n, last_n, nan_n, busy_n;
  logic [DATA_W-1:0]  fp32_n;
  logic [SCALE_W-1:0] oscale_n;
  logic [IDX_W-1:0]   idx_n;

  assign in_hs    = in_valid_i && in_ready_o;
  assign out_hs   = out_valid_o && out_ready_i;
  assign rcnt_inc = rcnt_q + IDX_W'(1);

  // Effective exponent of the incoming element and the running block maximum.
  always_comb begin
    exp_fld = in_fp32_i[30:23];
    if (exp_fld == 8'hFF) begin
      e_in = 8'hFF;
    end else if (exp_fld == 8'h00) begin
      e_in = 8'h01;
    end else begin
      e_in = exp_fld;
    end
    scale_upd = (e_in > scale_q) ? e_in : scale_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state and next-output decode; output registers are loaded from here.
  always_comb begin
    state_n  = state_q;
    wcnt_n   = wcnt_q;
    rcnt_n   = rcnt_q;
    len_n    = len_q;
    scale_n  = scale_q;
    ready_n  = in_ready_o;
    valid_n  = out_valid_o;
    first_n  = out_first_o;
    last_n   = out_last_o;
    nan_n    = nan_blk_o;
    busy_n   = busy_o;
    fp32_n   = out_fp32_o;
    oscale_n = out_scale_o;
    idx_n    = out_idx_o;
    case (state_q)
      S_FILL: begin
        if (in_hs) begin
          wcnt_n  = wcnt_q + IDX_W'(1);
          scale_n = scale_upd;
          if ((wcnt_q == LAST_WIDX) || in_last_i) begin
            state_n  = S_DRAIN;
            len_n    = LEN_W'(wcnt_q) + LEN_W'(1);
            rcnt_n   = '0;
            wcnt_n   = '0;
            ready_n  = 1'b0;
            busy_n   = 1'b1;
            valid_n  = 1'b1;
            // A one-element block is still being written this cycle.
            fp32_n   = (wcnt_q == '0) ? in_fp32_i : mem_q[0];
            oscale_n = scale_upd;
            idx_n    = '0;
            first_n  = 1'b1;
            last_n   = (wcnt_q == '0);
            nan_n    = (scale_upd == SCALE_NAN);
          end
        end
      end
      S_DRAIN: begin
        if (out_hs) begin
          if (out_last_o) begin
            state_n  = S_FILL;
            wcnt_n   = '0;
            rcnt_n   = '0;
            scale_n  = '0;
            ready_n  = 1'b1;
            busy_n   = 1'b0;
            valid_n  = 1'b0;
            first_n  = 1'b0;
            last_n   = 1'b0;
            nan_n    = 1'b0;
            fp32_n   = '0;
            oscale_n = '0;
            idx_n    = '0;
          end else begin
            rcnt_n  = rcnt_inc;
            fp32_n  = mem_q[rcnt_inc];
            idx_n   = rcnt_inc;
            first_n = 1'b0;
            last_n  = ((LEN_W'(rcnt_q) + LEN_W'(2)) == len_q);
          end
        end
      end
      default: begin
        state_n = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_n_reg_reset();
    end else begin
      wcnt_q      <= wcnt_n;
      rcnt_q      <= rcnt_n;
      len_q       <= len_n;
      scale_q     <= scale_n;
      in_ready_o  <= ready_n;
      out_valid_o <= valid_n;
      out_first_o <= first_n;
      out_last_o  <= last_n;
      nan_blk_o   <= nan_n;
      busy_o      <= busy_n;
      out_fp32_o  <= fp32_n;
      out_scale_o <= oscale_n;
      out_idx_o   <= idx_n;
    end
  end

  task automatic wcnt_n_reg_reset();
    wcnt_q      <= '0;
    rcnt_q      <= '0;
    len_q       <= '0;
    scale_q     <= '0;
    in_ready_o  <= 1'b1;
    out_valid_o <= 1'b0;
    out_first_o <= 1'b0;
    out_last_o  <= 1'b0;
    nan_blk_o   <= 1'b0;
    busy_o      <= 1'b0;
    out_fp32_o  <= '0;
    out_scale_o <= '0;
    out_idx_o   <= '0;
  endtask

  // Element buffer; contents need no reset since len gates every read.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem_q[wcnt_q] <= in_fp32_i;
    end
  end

endmodule

// File: tb/tb_mxint8_bd_seq.sv
// Directed bench for mxint8_bd_seq with a block-level reference model and a
// per-cycle output compare against the expected beat queue.
module tb_mxint8_bd_seq;

  localparam int unsigned BS = 4;
  localparam int unsigned IW = 2;

  logic          clk, rst_n;
  logic [31:0]   in_fp32;
  logic          in_valid, in_last, in_ready;
  logic [31:0]   out_fp32;
  logic [7:0]    out_scale;
  logic [IW-1:0] out_idx;
  logic          out_first, out_last, out_valid, out_ready, nan_blk, busy;

  mxint8_bd_seq #(.BLOCK_SIZE(BS), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_fp32_i(in_fp32), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_ready_o(in_ready),
    .out_fp32_o(out_fp32), .out_scale_o(out_scale), .out_idx_o(out_idx),
    .out_first_o(out_first), .out_last_o(out_last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .nan_blk_o(nan_blk), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  s;
    int          idx;
    bit          first;
    bit          last;
    bit          nan;
  } beat_t;

  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] eff_exp(input logic [31:0] x);
    logic [7:0] f;
    f = x[30:23];
    if (f == 8'hFF) return 8'hFF;
    if (f == 8'h00) return 8'h01;
    return f;
  endfunction

  // Per-cycle compare against the model queue, plus hold-stability under backpressure.
  logic        prev_hold = 1'b0;
  logic [63:0] prev_vec = '0;
  logic [63:0] cur_vec;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      cur_vec = 64'({out_fp32, out_scale, out_idx, out_first, out_last, nan_blk, out_valid, in_ready});
      if (prev_hold) chk("hold_stable", cur_vec, prev_vec);
      if (out_valid) begin
        chk("in_ready_drain", 64'(in_ready), 64'd0);
        chk("busy_drain", 64'(busy), 64'd1);
        if (exp_q.size() == 0) begin
          chk("stale_beat", 64'(out_valid), 64'd0);
        end else begin
          chk("beat_data",  64'(out_fp32), 64'(exp_q[0].d));
          chk("beat_scale", 64'(out_scale), 64'(exp_q[0].s));
          chk("beat_idx",   64'(out_idx), 64'(exp_q[0].idx));
          chk("beat_first", 64'(out_first), 64'(exp_q[0].first));
          chk("beat_last",  64'(out_last), 64'(exp_q[0].last));
          chk("beat_nan",   64'(nan_blk), 64'(exp_q[0].nan));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("in_ready_fill", 64'(in_ready), 64'd1);
        chk("busy_fill", 64'(busy), 64'd0);
      end
      prev_hold = out_valid && !out_ready;
      prev_vec  = cur_vec;
    end
  end

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"}, 64'(in_ready), 64'd1);
    chk({name, "_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_flags"}, 64'({out_first, out_last, nan_blk, busy}), 64'd0);
    chk({name, "_data"},  64'({out_fp32, out_scale, out_idx}), 64'd0);
  endtask

  // Drive one block; caller is at posedge+1 with the sequencer in FILL.
  task automatic send_block(input string name, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3, input int n,
                            input bit last_on_final, input logic [7:0] exp_scale);
    logic [31:0] el [4];
    logic [7:0]  sc;
    beat_t       b;
    el = '{e0, e1, e2, e3};
    sc = 8'h00;
    for (int i = 0; i < n; i++) if (eff_exp(el[i]) > sc) sc = eff_exp(el[i]);
    chk({name, "_model_scale"}, 64'(sc), 64'(exp_scale));
    chk({name, "_ready_pre"}, 64'(in_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      in_fp32  = el[i];
      in_valid = 1'b1;
      in_last  = (i == n - 1) && ((n < BS) || last_on_final);
      if (i == n - 1) begin
        for (int k = 0; k < n; k++) begin
          b.d = el[k]; b.s = sc; b.idx = k;
          b.first = (k == 0); b.last = (k == n - 1); b.nan = (sc == 8'hFF);
          exp_q.push_back(b);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_fp32  = 32'h0;
    chk({name, "_latency_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_first_scale"}, 64'(out_scale), 64'(exp_scale));
    chk({name, "_first_flag"}, 64'(out_first), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        chk({name, "_ready_after"}, 64'(in_ready), 64'd1);
        chk({name, "_valid_after"}, 64'(out_valid), 64'd0);
        return;
      end
    end
    chk({name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_idx(input string name, input int idx);
    for (int c = 0; c < 20; c++) begin
      if (out_valid && (out_idx == IW'(idx))) return;
      @(posedge clk); #1;
    end
    chk({name, "_idx_timeout"}, 64'(out_idx), 64'(idx));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_fp32 = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_block("normal", 32'h3F800000, 32'h40400000, 32'hC1200000, 32'h00000000, 4, 1'b0, 8'h82);
    wait_drain("normal");

    send_block("naninf", 32'h3F800000, 32'h7FC00000, 32'h42000000, 32'h7F800000, 4, 1'b0, 8'hFF);
    chk("naninf_nan_flag", 64'(nan_blk), 64'd1);
    wait_drain("naninf");

    send_block("subn", 32'h00000000, 32'h80000000, 32'h00000001, 32'h807FFFFF, 4, 1'b1, 8'h01);
    wait_drain("subn");

    send_block("short", 32'h40000000, 32'h3F000000, 32'h0, 32'h0, 2, 1'b1, 8'h80);
    wait_drain("short");
    send_block("after_short", 32'h3F800000, 32'h3F000000, 32'h3E800000, 32'hBF800000, 4, 1'b0, 8'h7F);
    wait_drain("after_short");

    send_block("single", 32'h40000000, 32'h0, 32'h0, 32'h0, 1, 1'b1, 8'h80);
    chk("single_last_flag", 64'(out_last), 64'd1);
    wait_drain("single");

    send_block("bp", 32'h41000000, 32'h3F800000, 32'h40800000, 32'hBF800000, 4, 1'b0, 8'h82);
    wait_idx("bp", 2);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held_idx", 64'(out_idx), 64'd2);
    chk("bp_held_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    wait_drain("bp");

    send_block("rst", 32'h43000000, 32'h3F800000, 32'h7F800000, 32'h3F800000, 4, 1'b0, 8'hFF);
    wait_idx("rst", 2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs("mid_drain_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_no_beat", 64'(out_valid), 64'd0);
    send_block("fresh", 32'h3E000000, 32'h3E800000, 32'h00000000, 32'h3D800000, 4, 1'b0, 8'h7D);
    wait_drain("fresh");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
